// File: rtl/ram_stream_pkg.sv
// Shared types and constants for the RAM word streamer and its byte serializer.
package ram_stream_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_UNPACK,
        S_FINISH
    } stream_state_t;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_W         = 8;

endpackage

// File: rtl/word_serializer.sv
// Word serializer: loads one RAM word and shifts it out as bytes on a
// valid/ready stream, least-significant byte first. Flags the last byte.
module word_serializer
    import ram_stream_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              ready,
    output logic              valid,
    output logic [BYTE_W-1:0] data,
    output logic              last,
    output logic              fire
);

    logic [DATA_W-1:0] shift_q, shift_d;
    logic [1:0]        idx_q, idx_d;
    logic              valid_q, valid_d;

    // Load a fresh word, or advance one byte on each accepted handshake.
    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        if (load) begin
            shift_d = load_data;
            idx_d   = '0;
            valid_d = 1'b1;
        end else if (valid_q && ready) begin
            shift_d = shift_q >> BYTE_W;
            idx_d   = idx_q + 2'd1;
            if (idx_q == 2'(BYTES_PER_WORD - 1)) begin
                valid_d = 1'b0;
            end
        end
    end

    // Shift register, byte index and valid flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    assign valid = valid_q;
    assign data  = shift_q[BYTE_W-1:0];
    assign last  = valid_q && (idx_q == 2'(BYTES_PER_WORD - 1));
    assign fire  = valid_q && ready;

endmodule

// File: rtl/ram_word_streamer.sv
// RAM word streamer: reads word_count consecutive words from base_addr, one
// word in flight at a time, and emits each as 4 little-endian bytes.
// Optional feature macro STREAM_CHECKSUM_EN adds a 16-bit running byte sum
// output (checksum), cleared on each accepted start.
module ram_word_streamer
    import ram_stream_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              byte_valid,
    output logic [BYTE_W-1:0] byte_data,
    input  logic              byte_ready,
    output logic              busy,
`ifdef STREAM_CHECKSUM_EN
    output logic [15:0]       checksum,
`endif
    output logic              done
);

    // WAIT spans RD_LAT cycles so the capture edge sees data for the address
    // that was already on mem_addr during ISSUE.
    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

    stream_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] words_left_q, words_left_d;
    logic [1:0]        wait_cnt_q, wait_cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              accept;
    logic              ser_load;
    logic              ser_fire;
    logic              ser_last;
    logic [BYTE_W-1:0] ser_data;

    word_serializer #(
        .DATA_W (DATA_W)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (ser_load),
        .load_data (mem_rdata),
        .ready     (byte_ready),
        .valid     (byte_valid),
        .data      (ser_data),
        .last      (ser_last),
        .fire      (ser_fire)
    );

    // Job sequencing: next state, address/word counters, busy and done.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        words_left_d = words_left_q;
        wait_cnt_d   = wait_cnt_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        ser_load     = 1'b0;
        accept       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // done_q high means the previous job is still signalling
                // completion; a start in that cycle is dropped.
                if (start && !done_q) begin
                    accept       = 1'b1;
                    addr_d       = base_addr;
                    words_left_d = word_count;
                    busy_d       = 1'b1;
                    state_d      = (word_count == '0) ? S_FINISH : S_ISSUE;
                end
            end
            S_ISSUE: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    ser_load = 1'b1;
                    state_d  = S_UNPACK;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            S_UNPACK: begin
                if (ser_fire && ser_last) begin
                    if (words_left_q > ADDR_W'(1)) begin
                        words_left_d = words_left_q - ADDR_W'(1);
                        addr_d       = addr_q + ADDR_W'(1);
                        state_d      = S_ISSUE;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            words_left_q <= '0;
            wait_cnt_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            words_left_q <= words_left_d;
            wait_cnt_q   <= wait_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign mem_addr  = addr_q;
    assign byte_data = ser_data;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef STREAM_CHECKSUM_EN
    logic [15:0] cksum_q, cksum_d;

    // Running byte sum, restarted on each accepted job.
    always_comb begin
        cksum_d = cksum_q;
        if (accept) begin
            cksum_d = '0;
        end else if (ser_fire) begin
            cksum_d = cksum_q + {{(16 - BYTE_W){1'b0}}, ser_data};
        end
    end

    // Checksum register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cksum_q <= '0;
        end else begin
            cksum_q <= cksum_d;
        end
    end

    assign checksum = cksum_q;
`endif

endmodule

// File: tb/tb_ram_word_streamer.sv
// Self-checking bench for ram_word_streamer: a job-level byte-queue model
// checks the stream every cycle; directed jobs pin the model with literals.
module tb_ram_word_streamer;

    localparam int unsigned RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        byte_ready = 1'b0;
    logic [15:0] base_addr = '0;
    logic [15:0] word_count = '0;
    logic [15:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        busy;
    logic        done;
`ifdef STREAM_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    logic [31:0] ram [0:65535];
    logic [31:0] rd_pipe [0:RD_LAT-1];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_word_streamer #(
        .ADDR_W (16),
        .DATA_W (32),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .busy       (busy),
`ifdef STREAM_CHECKSUM_EN
        .checksum   (checksum),
`endif
        .done       (done)
    );

    // RAM: data for an address appears RD_LAT clock edges after it is presented.
    always @(posedge clk) begin
        rd_pipe[0] <= ram[mem_addr];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RD_LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- job-level model ----------------
    logic [7:0]  exp_q[$];
    logic [7:0]  log_q[$];
    int          cyc = 0;
    int          done_due = -1;
    int          start_cyc = 0;
    int          last_done_cyc = -1;
    bit          job_active = 1'b0;
    bit          first_seen = 1'b0;
    bit          prev_stall = 1'b0;
    bit          exp_done;
    logic [7:0]  prev_data;
    logic [15:0] prev_addr;

    // Compare process: inputs are stable at the falling edge and the DUT
    // outputs seen here are what the next rising edge acts on.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            chk("reset_mem_addr", mem_addr, 16'h0);
            chk("reset_byte_valid", byte_valid, 1'b0);
            chk("reset_byte_data", byte_data, 8'h0);
            chk("reset_busy", busy, 1'b0);
            chk("reset_done", done, 1'b0);
            exp_q.delete();
            job_active = 1'b0;
            done_due   = -1;
            prev_stall = 1'b0;
        end else begin
            exp_done = (cyc == done_due);
            if (exp_done) job_active = 1'b0;
            if (done) last_done_cyc = cyc;
            chk("done", done, exp_done);
            chk("busy", busy, job_active);

            if (!job_active || exp_q.size() == 0) begin
                chk("valid_idle", byte_valid, 1'b0);
            end else if (byte_valid) begin
                chk("byte_data", byte_data, exp_q[0]);
                if (!first_seen) begin
                    first_seen = 1'b1;
                    chk("first_valid_latency", cyc - start_cyc, RD_LAT + 2);
                end
            end

            if (prev_stall) begin
                chk("stall_valid", byte_valid, 1'b1);
                chk("stall_data", byte_data, prev_data);
                chk("stall_addr", mem_addr, prev_addr);
            end
            prev_stall = byte_valid && !byte_ready;
            prev_data  = byte_data;
            prev_addr  = mem_addr;

            if (byte_valid && byte_ready && job_active && exp_q.size() > 0) begin
                log_q.push_back(byte_data);
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) done_due = cyc + 2;
            end

            if (start && !job_active && !exp_done) begin
                logic [31:0] w;
                job_active = 1'b1;
                start_cyc  = cyc;
                first_seen = 1'b0;
                for (int n = 0; n < int'(word_count); n++) begin
                    w = ram[base_addr + 16'(n)];
                    for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
                end
                if (word_count == 16'h0) done_due = cyc + 2;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start(input logic [15:0] b, input logic [15:0] c);
        base_addr  = b;
        word_count = c;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_job(input string name, input bit toggle, input int budget);
        int n = 0;
        while (job_active && n < budget) begin
            if (toggle) byte_ready = ~byte_ready;
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL %s_timeout actual=%0d cycles required<%0d", name, n, budget);
        end
    endtask

    task automatic check_log(input string name, input logic [63:0] bytes_le, input int nbytes);
        logic [63:0] v;
        v = bytes_le;
        chk({name, "_count"}, log_q.size(), nbytes);
        for (int i = 0; i < nbytes && i < log_q.size(); i++)
            chk($sformatf("%s_byte%0d", name, i), log_q[i], v[8*i +: 8]);
    endtask

    initial begin
        ram[16'h0010] = 32'h44332211;
        ram[16'h0011] = 32'h88776655;
        ram[16'hFFFF] = 32'hA4A3A2A1;
        ram[16'h0000] = 32'hB4B3B2B1;
        ram[16'h0020] = 32'hDEADBEEF;

        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();

        // Basic job, consumer always ready.
        byte_ready = 1'b1;
        log_q.delete();
        pulse_start(16'h0010, 16'd2);
        wait_job("basic", 1'b0, 100);
        check_log("basic", 64'h8877665544332211, 8);
`ifdef STREAM_CHECKSUM_EN
        chk("basic_checksum", checksum, 16'h0264);
`endif
        repeat (2) tick();

        // Same job with alternating backpressure.
        byte_ready = 1'b1;
        log_q.delete();
        pulse_start(16'h0010, 16'd2);
        wait_job("backpressure", 1'b1, 200);
        check_log("backpressure", 64'h8877665544332211, 8);
        byte_ready = 1'b1;
        repeat (2) tick();

        // Address wrap from 0xFFFF to 0x0000.
        log_q.delete();
        pulse_start(16'hFFFF, 16'd2);
        wait_job("wrap", 1'b0, 100);
        check_log("wrap", 64'hB4B3B2B1A4A3A2A1, 8);
        repeat (2) tick();

        // Empty job: done two cycles after start, no bytes.
        log_q.delete();
        pulse_start(16'h0020, 16'd0);
        wait_job("empty", 1'b0, 20);
        chk("empty_done_delay", last_done_cyc - start_cyc, 2);
        chk("empty_bytes", log_q.size(), 0);
        repeat (2) tick();

        // Start while busy must not disturb the running job.
        log_q.delete();
        pulse_start(16'h0010, 16'd2);
        repeat (3) tick();
        pulse_start(16'h0011, 16'd5);
        wait_job("busy_start", 1'b0, 100);
        check_log("busy_start", 64'h8877665544332211, 8);
        repeat (2) tick();

        // Start in the same cycle as done is ignored.
        begin
            int n = 0;
            pulse_start(16'h0010, 16'd1);
            while (!done && n < 50) begin
                tick();
                n++;
            end
            chk("done_seen_for_overlap", done, 1'b1);
            log_q.delete();
            pulse_start(16'h0010, 16'd1);
            repeat (10) tick();
            chk("overlap_start_bytes", log_q.size(), 0);
            chk("overlap_start_busy", busy, 1'b0);
        end

        // Reset in the middle of a word: outputs clear at once, no done later.
        begin
            int n = 0;
            log_q.delete();
            pulse_start(16'h0010, 16'd2);
            while (!byte_valid && n < 50) begin
                tick();
                n++;
            end
            tick();
            chk("pre_reset_valid", byte_valid, 1'b1);
            rst = 1'b0;
            #1;
            chk("async_reset_valid", byte_valid, 1'b0);
            chk("async_reset_data", byte_data, 8'h0);
            chk("async_reset_addr", mem_addr, 16'h0);
            chk("async_reset_busy", busy, 1'b0);
            chk("async_reset_done", done, 1'b0);
            repeat (2) tick();
            rst = 1'b1;
            last_done_cyc = -1;
            repeat (12) tick();
            chk("no_done_after_abort", last_done_cyc, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0t required<200000", $time);
        $fatal(1, "simulation time limit");
    end

endmodule
